// File: rtl/pe_seq_pkg.sv
// Shared definitions for the PE beat sequencer: FSM encoding, pe_ctl bit
// positions and the instruction iteration-count width.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int PE_CTL_FIRST = 0;
  localparam int PE_CTL_LAST  = 1;
  localparam int CNT_W        = 8;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pe_seq_align.sv
// One-cycle delay of the read strobe and beat markers so they line up with
// the neuron/weight data returned by memory.
module pe_seq_align
  import pe_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_en,
  input  logic [1:0] ctl_in,
  output logic       vld_p1,
  output logic [1:0] ctl_p1
);

  // stage p0 -> p1: markers are forced to zero on bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ctl_p1 <= 2'b00;
    end else begin
      vld_p1 <= rd_en;
      ctl_p1 <= rd_en ? ctl_in : 2'b00;
    end
  end

endmodule

// File: rtl/pe_seq.sv
// Instruction-driven beat sequencer: fetches per-instruction iteration counts,
// issues contiguous memory reads to parallel_pe and waits for all results.
module pe_seq
  import pe_seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INST_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INST_AW:0]   inst_num,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               hold,
  output logic [INST_AW-1:0] inst_addr,
  input  logic [CNT_W-1:0]   inst_data,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               pe_vld,
  output logic [1:0]         pe_ctl,
  input  logic               pe_vld_o,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int NUM_W = INST_AW + 1;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [INST_AW-1:0] inst_idx;
  logic [NUM_W-1:0]   num;
  logic [NUM_W-1:0]   exp_cnt;
  logic [NUM_W-1:0]   got_cnt;
  logic [NUM_W-1:0]   got_nxt;
  cnt_t               cnt;
  cnt_t               iter;
  logic               rd_en;
  logic               last_beat;
  logic               last_inst;
  logic               res_in;
  logic               accept;
  logic               proto_err;
  logic [1:0]         ctl;

  assign rd_en     = (state == S_ISSUE) && !hold;
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr;
  assign inst_addr = inst_idx;

  assign last_beat = (iter == cnt - CNT_W'(1));
  assign last_inst = (({1'b0, inst_idx} + NUM_W'(1)) == num);
  assign res_in    = pe_vld_o && (state != S_IDLE);
  assign got_nxt   = got_cnt + NUM_W'(res_in);
  assign accept    = (state == S_IDLE) && start;

  // A result is unexpected when idle or once every issued instruction is answered.
  assign proto_err = pe_vld_o && ((state == S_IDLE) ||
                     (((state == S_DRAIN) || (state == S_DONE)) && (got_cnt == exp_cnt)));

  always_comb begin
    ctl               = 2'b00;
    ctl[PE_CTL_FIRST] = (iter == '0);
    ctl[PE_CTL_LAST]  = last_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      inst_idx <= '0;
      num      <= '0;
      exp_cnt  <= '0;
      got_cnt  <= '0;
      cnt      <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= proto_err | (err & ~accept);
      if (res_in) got_cnt <= got_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            num     <= inst_num;
            exp_cnt <= '0;
            got_cnt <= '0;
            if (inst_num != '0) begin
              addr     <= base_addr;
              inst_idx <= '0;
              state    <= S_FETCH;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          cnt  <= inst_data;
          iter <= '0;
          if (inst_data == '0) begin
            if (last_inst) begin
              state <= S_DRAIN;
            end else begin
              inst_idx <= inst_idx + INST_AW'(1);
              state    <= S_FETCH;
            end
          end else begin
            exp_cnt <= exp_cnt + NUM_W'(1);
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!hold) begin
            addr <= addr + ADDR_W'(1);
            iter <= iter + CNT_W'(1);
            if (last_beat) begin
              if (last_inst) begin
                state <= S_DRAIN;
              end else begin
                inst_idx <= inst_idx + INST_AW'(1);
                state    <= S_FETCH;
              end
            end
          end
        end
        S_DRAIN: begin
          if (got_nxt == exp_cnt) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  pe_seq_align u_align (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rd_en),
    .ctl_in (ctl),
    .vld_p1 (pe_vld),
    .ctl_p1 (pe_ctl)
  );

endmodule

// File: tb/tb_pe_seq.sv
// Self-checking bench for pe_seq: instruction ROM and PE result models, beat
// scoreboard, table-driven programs and hand-written reset/start sequences.
module tb_pe_seq;

  localparam int ADDR_W  = 16;
  localparam int INST_AW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [INST_AW:0]   inst_num;
  logic [ADDR_W-1:0]  base_addr;
  logic               hold;
  logic [INST_AW-1:0] inst_addr;
  logic [7:0]         inst_data;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic               pe_vld;
  logic [1:0]         pe_ctl;
  logic               pe_vld_o;
  logic               busy;
  logic               done;
  logic               err;

  logic [7:0] rom [4];
  logic [3:0] sh;
  logic       force_vo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_seq #(.ADDR_W(ADDR_W), .INST_AW(INST_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inst_num  (inst_num),
    .base_addr (base_addr),
    .hold      (hold),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .pe_vld    (pe_vld),
    .pe_ctl    (pe_ctl),
    .pe_vld_o  (pe_vld_o),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Synchronous instruction ROM and a PE that answers 4 cycles after a last beat.
  always @(posedge clk) inst_data <= rom[inst_addr];
  always @(posedge clk) begin
    if (rst) sh <= 4'b0;
    else     sh <= {sh[2:0], pe_vld & pe_ctl[1]};
  end
  assign pe_vld_o = sh[3] | force_vo;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  ctl;
  } beat_t;

  typedef struct packed {
    logic [3:0][7:0] c;
    logic [2:0]      n;
    logic [15:0]     base;
    logic            hmode;
    logic            bstart;
    logic [15:0]     beats;
    logic [15:0]     results;
  } vec_t;

  beat_t       sbq[$];
  beat_t       b;
  int          beat_cyc[$];
  int          cyc_no   = 0;
  int          done_cnt = 0;
  int          beat_cnt = 0;
  int          vo_cnt   = 0;
  logic [15:0] last_addr = '0;
  logic        last_rd   = 1'b0;
  int          nissued, hcnt;
  bit          hold_mode;
  vec_t        tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every beat, using the address issued one cycle earlier.
  always @(negedge clk) begin
    cyc_no++;
    if (!rst) begin
      if (done) done_cnt++;
      if (pe_vld_o) vo_cnt++;
      chk("pe_vld_align", {31'b0, pe_vld}, {31'b0, last_rd});
      if (pe_vld) begin
        beat_cyc.push_back(cyc_no);
        beat_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = sbq.pop_front();
          chk("beat_addr", {16'b0, last_addr}, {16'b0, b.addr});
          chk("beat_ctl", {30'b0, pe_ctl}, {30'b0, b.ctl});
        end
      end else if (pe_ctl != 2'b00) begin
        chk("ctl_idle", {30'b0, pe_ctl}, 32'd0);
      end
    end
    last_addr = mem_addr;
    last_rd   = mem_rd_en & ~rst;
  end

  // One clock; re-decides hold each cycle so beats 3..5 can each be stalled twice.
  task automatic cyc();
    @(posedge clk);
    #1 hold = 1'b0;
    #1;
    if (mem_rd_en) begin
      if (hold_mode && nissued >= 3 && nissued <= 5 && hcnt < 2) begin
        hold = 1'b1;
        hcnt++;
      end else begin
        nissued++;
        hcnt = 0;
      end
    end
  endtask

  task automatic push_prog(input int n, input logic [15:0] base);
    logic [15:0] a;
    int c;
    a = base;
    for (int i = 0; i < n; i++) begin
      c = int'(rom[i]);
      for (int j = 0; j < c; j++) begin
        sbq.push_back({a, (j == c - 1), (j == 0)});
        a = a + 16'd1;
      end
    end
  endtask

  task automatic run_prog(input vec_t v);
    int d0, b0, v0, k;
    for (int i = 0; i < 4; i++) rom[i] = v.c[i];
    d0 = done_cnt; b0 = beat_cnt; v0 = vo_cnt;
    beat_cyc.delete();
    nissued = 0; hcnt = 0; hold_mode = v.hmode;
    push_prog(int'(v.n), v.base);
    inst_num = v.n; base_addr = v.base; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("err_after_start", {31'b0, err}, 32'd0);
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      if (v.bstart && k == 10) begin
        inst_num = '0;
        start    = 1'b1;
      end
      cyc();
      start = 1'b0;
      k++;
    end
    if (k >= 3000) chk("done_timeout", 32'd1, 32'd0);
    repeat (3) cyc();
    chk("done_count", done_cnt - d0, 32'd1);
    chk("beat_count", beat_cnt - b0, {16'b0, v.beats});
    chk("result_count", vo_cnt - v0, {16'b0, v.results});
    chk("scoreboard_empty", sbq.size(), 32'd0);
    chk("err_end", {31'b0, err}, 32'd0);
    chk("busy_end", {31'b0, busy}, 32'd0);
    if (v.hmode) begin
      chk("gap_b3", beat_cyc[3] - beat_cyc[2], 32'd3);
      chk("gap_b4", beat_cyc[4] - beat_cyc[3], 32'd3);
      chk("gap_b5", beat_cyc[5] - beat_cyc[4], 32'd3);
      chk("gap_b6", beat_cyc[6] - beat_cyc[5], 32'd1);
    end
    hold_mode = 1'b0;
  endtask

  initial begin
    int d0, b0, k;
    rst = 1'b1; start = 1'b0; hold = 1'b0; force_vo = 1'b0;
    inst_num = '0; base_addr = '0;
    for (int i = 0; i < 4; i++) rom[i] = 8'd0;
    nissued = 0; hcnt = 0; hold_mode = 1'b0;

    //                c[3..0]                            n     base       hm    bs    beats   res
    tbl[0] = '{{8'd50, 8'd40, 8'd30, 8'd20}, 3'd4, 16'h0000, 1'b0, 1'b0, 16'd140, 16'd4};
    tbl[1] = '{{8'd0,  8'd3,  8'd0,  8'd1 }, 3'd4, 16'h0100, 1'b0, 1'b0, 16'd4,   16'd2};
    tbl[2] = '{{8'd0,  8'd0,  8'd0,  8'd8 }, 3'd1, 16'h0020, 1'b1, 1'b0, 16'd8,   16'd1};
    tbl[3] = '{{8'd0,  8'd0,  8'd0,  8'd4 }, 3'd1, 16'hFFFE, 1'b0, 1'b0, 16'd4,   16'd1};
    tbl[4] = '{{8'd0,  8'd0,  8'd5,  8'd6 }, 3'd2, 16'h0040, 1'b0, 1'b1, 16'd11,  16'd2};
    tbl[5] = '{{8'd0,  8'd0,  8'd0,  8'd0 }, 3'd3, 16'h0000, 1'b0, 1'b0, 16'd0,   16'd0};

    repeat (3) cyc();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("rst_pe_vld", {31'b0, pe_vld}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_inst_addr", {30'b0, inst_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) cyc();

    for (int t = 0; t < 6; t++) run_prog(tbl[t]);

    // Reset in the middle of issuing, then a stray result while idle.
    rom[0] = 8'd8;
    d0 = done_cnt; b0 = beat_cnt;
    push_prog(1, 16'h0200);
    inst_num = 3'd1; base_addr = 16'h0200; start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (beat_cnt < b0 + 3 && k < 100) begin cyc(); k++; end
    if (k >= 100) chk("beat_timeout", 32'd1, 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sbq.delete();
    chk("abort_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("abort_pe_vld", {31'b0, pe_vld}, 32'd0);
    chk("abort_pe_ctl", {30'b0, pe_ctl}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);
    chk("abort_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("abort_inst_addr", {30'b0, inst_addr}, 32'd0);
    force_vo = 1'b1;
    cyc();
    force_vo = 1'b0;
    repeat (3) cyc();
    chk("stray_result_err", {31'b0, err}, 32'd1);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    // The next accepted start clears err; run_prog checks it.
    run_prog(tbl[1]);

    // Zero-instruction start from idle completes with no beats.
    d0 = done_cnt; b0 = beat_cnt;
    inst_num = '0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("zero_done", done_cnt - d0, 32'd1);
    chk("zero_beats", beat_cnt - b0, 32'd0);
    chk("zero_busy", {31'b0, busy}, 32'd0);
    chk("zero_err", {31'b0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
